// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS pipeline types: forwarding select codes and the
//                scoreboard slot used by the ID-stage forwarding controller.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Operand mux select codes for the ID-stage 4-to-1 forwarding muxes
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Register index width carried in a scoreboard slot
    localparam int SLOT_REG_W = 5;

    // One in-flight register write tracked by the scoreboard
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [SLOT_REG_W-1:0] dest;
        logic                  is_load;
    } sb_slot_t;

    // A slot supplies source r when it is a live write to r; r0 is hardwired
    // to zero, so it never matches
    function automatic logic slot_match(input sb_slot_t slot,
                                        input logic [SLOT_REG_W-1:0] r);
        return slot.valid & slot.reg_write & (slot.dest == r) & (r != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_fwd_select_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_fwd_select_unit_if
//  Description : ID-stage instruction fields in, forwarding selects, stall
//                and stall counter out.
//  Revision    : 1.0  initial release
// ============================================================================
interface id_fwd_select_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_reg_write;
    logic [REG_W-1:0] id_dest;
    logic             id_mem_read;
    logic             flush;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side that presents the ID instruction
    modport master (
        output id_valid, id_rs, id_rt, id_reg_write, id_dest, id_mem_read, flush,
        input  sel_a, sel_b, stall, stall_count
    );

    // Forwarding controller side
    modport slave (
        input  id_valid, id_rs, id_rt, id_reg_write, id_dest, id_mem_read, flush,
        output sel_a, sel_b, stall, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/id_fwd_select_unit_fwd_operand_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_operand_sel
//  Description : Combinational forwarding select and load-use hazard for one
//                source operand, youngest producer first (EX, MEM, WB, RF).
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_operand_sel
    import mips_pkg::*;
(
    input  wire sb_slot_t              i_ex_slot,
    input  wire sb_slot_t              i_mem_slot,
    input  wire sb_slot_t              i_wb_slot,
    input  wire [SLOT_REG_W-1:0]       i_src,
    output logic [1:0]                 o_sel,
    output logic                       o_hazard
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_ex_hit  = slot_match(i_ex_slot,  i_src);
    assign w_mem_hit = slot_match(i_mem_slot, i_src);
    assign w_wb_hit  = slot_match(i_wb_slot,  i_src);

    // Pick the youngest matching producer; a load is only usable once in WB
    always_comb begin
        o_sel    = SEL_RF;
        o_hazard = 1'b0;
        if (w_ex_hit) begin
            o_sel    = SEL_EX;
            o_hazard = i_ex_slot.is_load;
        end else if (w_mem_hit) begin
            o_sel    = SEL_MEM;
            o_hazard = i_mem_slot.is_load;
        end else if (w_wb_hit) begin
            o_sel    = SEL_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_fwd_select_unit.sv
`default_nettype none
// ============================================================================
//  Module      : id_fwd_select_unit
//  Description : ID-stage operand-forwarding controller. Tracks in-flight
//                register writes in an EX/MEM/WB scoreboard, drives the rs/rt
//                forwarding selects, raises load-use stalls and counts them.
//  Revision    : 1.0  initial release
// ============================================================================
module id_fwd_select_unit
    import mips_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
)(
    input wire                  clk,
    input wire                  rst_n,
    id_fwd_select_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    sb_slot_t r_ex_slot;
    sb_slot_t r_mem_slot;
    sb_slot_t r_wb_slot;
    sb_slot_t w_id_slot;

    logic [CNT_W-1:0] r_stall_count;

    logic [REG_W-1:0] w_rs;
    logic [REG_W-1:0] w_rt;
    logic [REG_W-1:0] w_dest;
    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_stall;

    assign w_rs   = bus.id_rs;
    assign w_rt   = bus.id_rt;
    assign w_dest = bus.id_dest;

    fwd_operand_sel u_sel_rs (
        .i_ex_slot  (r_ex_slot),
        .i_mem_slot (r_mem_slot),
        .i_wb_slot  (r_wb_slot),
        .i_src      (SLOT_REG_W'(w_rs)),
        .o_sel      (w_sel_a),
        .o_hazard   (w_haz_a)
    );

    // rt is checked for every instruction; stalling on an unused rt is harmless
    fwd_operand_sel u_sel_rt (
        .i_ex_slot  (r_ex_slot),
        .i_mem_slot (r_mem_slot),
        .i_wb_slot  (r_wb_slot),
        .i_src      (SLOT_REG_W'(w_rt)),
        .o_sel      (w_sel_b),
        .o_hazard   (w_haz_b)
    );

    assign w_stall = bus.id_valid & (w_haz_a | w_haz_b);

    // Entry for the ID instruction; a stalled or flushed instruction becomes a bubble
    always_comb begin
        w_id_slot           = '0;
        w_id_slot.valid     = bus.id_valid & ~bus.flush & ~w_stall;
        w_id_slot.reg_write = bus.id_reg_write;
        w_id_slot.dest      = SLOT_REG_W'(w_dest);
        w_id_slot.is_load   = bus.id_mem_read;
    end

    // Scoreboard advances every cycle; stalls only affect what enters EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_slot  <= '0;
            r_mem_slot <= '0;
            r_wb_slot  <= '0;
        end else begin
            r_ex_slot  <= w_id_slot;
            r_mem_slot <= r_ex_slot;
            r_wb_slot  <= r_mem_slot;
        end
    end

    // Saturating count of stall cycles that were not overridden by a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && !bus.flush && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.sel_a       = w_sel_a;
    assign bus.sel_b       = w_sel_b;
    assign bus.stall       = w_stall;
    assign bus.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_fwd_select_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_fwd_select_unit
//  Description : Directed self-checking bench for id_fwd_select_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_fwd_select_unit;

    localparam int TB_CNT_W = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_cnt;

    id_fwd_select_unit_if #(.REG_W(5), .CNT_W(TB_CNT_W)) bus ();

    id_fwd_select_unit #(.REG_W(5), .CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one ID instruction for a cycle; outputs are settled on return
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rw, input logic [4:0] dest, input logic ld,
                         input logic fl);
        @(posedge clk);
        #1;
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_reg_write = rw;
        bus.id_dest      = dest;
        bus.id_mem_read  = ld;
        bus.flush        = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_reg_write = 1'b0;
        bus.id_dest = '0; bus.id_mem_read = 1'b0; bus.flush = 1'b0;
        #12;
        checks++; if (bus.sel_a !== 2'b00) begin errors++; $display("FAIL reset sel_a: got %b want 00", bus.sel_a); end
        checks++; if (bus.sel_b !== 2'b00) begin errors++; $display("FAIL reset sel_b: got %b want 00", bus.sel_b); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset stall: got %b want 0", bus.stall); end
        checks++; if (bus.stall_count !== '0) begin errors++; $display("FAIL reset stall_count: got %0d want 0", bus.stall_count); end
        rst_n = 1'b1;
        idle(2);
        checks++; if (bus.stall_count !== '0 || bus.sel_a !== 2'b00) begin errors++; $display("FAIL idle: got cnt=%0d sel_a=%b want 0/00", bus.stall_count, bus.sel_a); end
    endtask

    task automatic test_alu_forward;
        logic [1:0] exp_sel [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL alu producer stall: got %b want 0", bus.stall); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            checks++; if (bus.sel_a !== exp_sel[i]) begin errors++; $display("FAIL alu t+%0d sel_a: got %b want %b", i + 1, bus.sel_a, exp_sel[i]); end
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL alu t+%0d stall: got %b want 0", i + 1, bus.stall); end
        end
    endtask

    task automatic test_load_use;
        logic [1:0] exp_sel [3] = '{2'b01, 2'b10, 2'b11};
        logic       exp_stl [3] = '{1'b1, 1'b1, 1'b0};
        idle(3);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
            checks++; if (bus.stall !== exp_stl[i]) begin errors++; $display("FAIL load_use c%0d stall: got %b want %b", i, bus.stall, exp_stl[i]); end
            checks++; if (bus.sel_b !== exp_sel[i]) begin errors++; $display("FAIL load_use c%0d sel_b: got %b want %b", i, bus.sel_b, exp_sel[i]); end
        end
        exp_cnt += 2;
        checks++; if (bus.stall_count !== TB_CNT_W'(exp_cnt)) begin errors++; $display("FAIL load_use stall_count: got %0d want %0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_r0;
        idle(3);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0 stall: got %b want 0", bus.stall); end
        checks++; if (bus.sel_a !== 2'b00) begin errors++; $display("FAIL r0 sel_a: got %b want 00", bus.sel_a); end
        checks++; if (bus.sel_b !== 2'b00) begin errors++; $display("FAIL r0 sel_b: got %b want 00", bus.sel_b); end
    endtask

    task automatic test_same_dest;
        idle(3);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (bus.sel_a !== 2'b01) begin errors++; $display("FAIL same_dest sel_a: got %b want 01", bus.sel_a); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL same_dest stall: got %b want 0", bus.stall); end
    endtask

    task automatic test_load_over_alu;
        logic [1:0] exp_sel [3] = '{2'b01, 2'b10, 2'b11};
        logic       exp_stl [3] = '{1'b1, 1'b1, 1'b0};
        idle(3);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
            checks++; if (bus.stall !== exp_stl[i]) begin errors++; $display("FAIL load_over_alu c%0d stall: got %b want %b", i, bus.stall, exp_stl[i]); end
            checks++; if (bus.sel_b !== exp_sel[i]) begin errors++; $display("FAIL load_over_alu c%0d sel_b: got %b want %b", i, bus.sel_b, exp_sel[i]); end
        end
        exp_cnt += 2;
        checks++; if (bus.stall_count !== TB_CNT_W'(exp_cnt)) begin errors++; $display("FAIL load_over_alu stall_count: got %0d want %0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_flush;
        idle(3);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        drive(1'b1, 5'd3, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush stall: got %b want 1", bus.stall); end
        checks++; if (bus.sel_a !== 2'b01) begin errors++; $display("FAIL flush sel_a: got %b want 01", bus.sel_a); end
        drive(1'b1, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (bus.sel_b !== 2'b00) begin errors++; $display("FAIL flush bubble sel_b: got %b want 00", bus.sel_b); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush bubble stall: got %b want 0", bus.stall); end
        checks++; if (bus.stall_count !== TB_CNT_W'(exp_cnt)) begin errors++; $display("FAIL flush stall_count: got %0d want %0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_saturate_and_reset;
        bit seen;
        idle(3);
        for (int i = 0; i < 1800; i++) drive(1'b1, 5'd0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0);
        checks++; if (bus.stall_count !== {TB_CNT_W{1'b1}}) begin errors++; $display("FAIL saturate stall_count: got %h want %h", bus.stall_count, {TB_CNT_W{1'b1}}); end
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            drive(1'b1, 5'd0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0);
            seen = (bus.stall === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL async_reset wait: got no stall within 6 cycles want stall=1"); end
        checks++; if (bus.stall_count !== {TB_CNT_W{1'b1}}) begin errors++; $display("FAIL saturate hold: got %h want %h", bus.stall_count, {TB_CNT_W{1'b1}}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL async_reset stall: got %b want 0", bus.stall); end
        checks++; if (bus.stall_count !== '0) begin errors++; $display("FAIL async_reset stall_count: got %0d want 0", bus.stall_count); end
        checks++; if (bus.sel_b !== 2'b00) begin errors++; $display("FAIL async_reset sel_b: got %b want 00", bus.sel_b); end
        #10;
        rst_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_r0();
        test_same_dest();
        test_load_over_alu();
        test_flush();
        test_saturate_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
